// File: rtl/tx_redundant_framer.sv
// ---------------------------------------------------------------------------
// tx_redundant_framer
//
// Builds complete Ethernet frames (preamble/SFD, header, zero pad, ID bytes,
// payload, CRC-32 FCS, inter-frame gap) and sends each segment `redundancy`
// times. This lets the receiver vote on each byte across the copies.
// Byte slots advance only on clock edges where tx_adv is high.
//
// Ports:
//   clk125MHz          in   1  sole clock
//   resetn             in   1  synchronous reset, active low
//   tx_adv             in   1  byte strobe; state advances only when high
//   start              in   1  burst request, sampled in IDLE only
//   redundancy         in   8  copies per segment (0 treated as 1), latched on start
//   segment_number_max in   8  segments per burst (0 treated as 1), latched on start
//   pl_addr            out 16  payload index consumed on the next advancing edge
//   pl_data            in   8  payload byte, combinational function of pl_addr
//   tx_data            out  8  byte to RGMII TX (0 while tx_en is low)
//   tx_en              out  1  high from preamble through FCS
//   busy               out  1  high from start acceptance until done
//   done               out  1  one-cycle pulse at the end of a burst
//
// Optional feature (macro TX_ERR_INJECT_EN):
//   Adds err_mask[7:0] and err_copy[7:0], both sampled at the first preamble
//   byte of each frame. On the copy whose index equals err_copy, payload
//   byte 0 is XORed with err_mask before it enters the CRC, so the frame
//   stays valid on the wire.
// ---------------------------------------------------------------------------
module tx_redundant_framer #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0018_3E02_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          ID_OFFSET   = 25,
  parameter int          PAYLOAD_LEN = 64,
  parameter int          IFG_BYTES   = 12
) (
  input  logic        clk125MHz,
  input  logic        resetn,
  input  logic        tx_adv,
  input  logic        start,
  input  logic [7:0]  redundancy,
  input  logic [7:0]  segment_number_max,
`ifdef TX_ERR_INJECT_EN
  input  logic [7:0]  err_mask,
  input  logic [7:0]  err_copy,
`endif
  output logic [15:0] pl_addr,
  input  logic [7:0]  pl_data,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAD, S_IDS, S_PAY, S_FCS, S_IFG, S_FIN
  } state_t;

  // Header bytes, MSB first: DST(6) SRC(6) ETHERTYPE(2) = frame bytes 0..13
  localparam logic [111:0] HDR       = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [15:0]  HDR_LAST  = 16'd13;
  localparam logic [15:0]  PAD_LAST  = 16'(ID_OFFSET - 1);
  localparam logic [15:0]  IDS_SEQ   = 16'(ID_OFFSET);
  localparam logic [15:0]  IDS_SEG   = 16'(ID_OFFSET + 1);
  localparam logic [15:0]  IDS_LAST  = 16'(ID_OFFSET + 2);
  localparam logic [15:0]  PAY_LAST  = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0]  IFG_LAST  = 16'(IFG_BYTES - 1);
  localparam logic [31:0]  CRC_INIT  = 32'hFFFF_FFFF;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  copy_q, copy_d;
  logic [7:0]  red_q, red_d;
  logic [7:0]  segmax_q, segmax_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] pl_addr_d;
  logic [7:0]  tx_data_d;
  logic        tx_en_d, busy_d, done_d;
  logic [7:0]  byte_v;
  logic [6:0]  hdr_base;
  logic [31:0] fcs_word;
  logic [4:0]  fcs_base;
`ifdef TX_ERR_INJECT_EN
  logic [7:0]  err_mask_q, err_mask_d;
  logic [7:0]  err_copy_q, err_copy_d;
`endif

  // State and output registers; every output is registered here.
  always_ff @(posedge clk125MHz) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      seq_q    <= '0;
      seg_q    <= '0;
      copy_q   <= '0;
      red_q    <= 8'd1;
      segmax_q <= 8'd1;
      crc_q    <= CRC_INIT;
      pl_addr  <= '0;
      tx_data  <= '0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TX_ERR_INJECT_EN
      err_mask_q <= '0;
      err_copy_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      seg_q    <= seg_d;
      copy_q   <= copy_d;
      red_q    <= red_d;
      segmax_q <= segmax_d;
      crc_q    <= crc_d;
      pl_addr  <= pl_addr_d;
      tx_data  <= tx_data_d;
      tx_en    <= tx_en_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef TX_ERR_INJECT_EN
      err_mask_q <= err_mask_d;
      err_copy_q <= err_copy_d;
`endif
    end
  end

  // Next-state and next-output logic. cnt holds the frame byte index through
  // HDR/PAD/IDS so header, pad and ID bytes share one counter; PAY uses pl_addr.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    seg_d     = seg_q;
    copy_d    = copy_q;
    red_d     = red_q;
    segmax_d  = segmax_q;
    crc_d     = crc_q;
    pl_addr_d = pl_addr;
    tx_data_d = tx_data;
    tx_en_d   = tx_en;
    busy_d    = busy;
    done_d    = 1'b0;
    byte_v    = 8'h00;
    hdr_base  = {(4'd13 - cnt_q[3:0]), 3'b000};
    fcs_word  = ~crc_q;
    fcs_base  = {cnt_q[1:0], 3'b000};
`ifdef TX_ERR_INJECT_EN
    err_mask_d = err_mask_q;
    err_copy_d = err_copy_q;
`endif

    if (state_q == S_IDLE) begin
      if (start) begin
        red_d     = (redundancy == 8'd0) ? 8'd1 : redundancy;
        segmax_d  = (segment_number_max == 8'd0) ? 8'd1 : segment_number_max;
        busy_d    = 1'b1;
        copy_d    = '0;
        seg_d     = '0;
        cnt_d     = '0;
        pl_addr_d = '0;
        state_d   = S_PRE;
      end
    end else if (tx_adv) begin
      case (state_q)
        S_PRE: begin
          tx_en_d   = 1'b1;
          tx_data_d = 8'h55;
          crc_d     = CRC_INIT;
`ifdef TX_ERR_INJECT_EN
          if (cnt_q == 16'd0) begin
            err_mask_d = err_mask;
            err_copy_d = err_copy;
          end
`endif
          if (cnt_q == 16'd6) begin
            cnt_d   = '0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_SFD: begin
          tx_en_d   = 1'b1;
          tx_data_d = 8'hD5;
          cnt_d     = '0;
          state_d   = S_HDR;
        end
        S_HDR: begin
          byte_v    = HDR[hdr_base +: 8];
          tx_en_d   = 1'b1;
          tx_data_d = byte_v;
          crc_d     = crc32_byte(crc_q, byte_v);
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == HDR_LAST) begin
            state_d = (ID_OFFSET > 14) ? S_PAD : S_IDS;
          end
        end
        S_PAD: begin
          tx_en_d   = 1'b1;
          tx_data_d = 8'h00;
          crc_d     = crc32_byte(crc_q, 8'h00);
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == PAD_LAST) begin
            state_d = S_IDS;
          end
        end
        S_IDS: begin
          if (cnt_q == IDS_SEQ) begin
            byte_v = seq_q;
          end else if (cnt_q == IDS_SEG) begin
            byte_v = seg_q;
          end else begin
            byte_v = copy_q;
          end
          tx_en_d   = 1'b1;
          tx_data_d = byte_v;
          crc_d     = crc32_byte(crc_q, byte_v);
          if (cnt_q == IDS_LAST) begin
            cnt_d     = '0;
            pl_addr_d = '0;
            state_d   = S_PAY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_PAY: begin
          byte_v = pl_data;
`ifdef TX_ERR_INJECT_EN
          if ((pl_addr == 16'd0) && (copy_q == err_copy_q)) begin
            byte_v = pl_data ^ err_mask_q;
          end
`endif
          tx_en_d   = 1'b1;
          tx_data_d = byte_v;
          crc_d     = crc32_byte(crc_q, byte_v);
          if (pl_addr == PAY_LAST) begin
            pl_addr_d = '0;
            cnt_d     = '0;
            state_d   = S_FCS;
          end else begin
            pl_addr_d = pl_addr + 16'd1;
          end
        end
        S_FCS: begin
          tx_en_d   = 1'b1;
          tx_data_d = fcs_word[fcs_base +: 8];
          if (cnt_q == 16'd3) begin
            cnt_d   = '0;
            state_d = S_IFG;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_IFG: begin
          tx_en_d   = 1'b0;
          tx_data_d = 8'h00;
          if (cnt_q == IFG_LAST) begin
            cnt_d = '0;
            // Repeat the same segment, move to the next one, or wrap up the burst
            if (({1'b0, copy_q} + 9'd1) < {1'b0, red_q}) begin
              copy_d  = copy_q + 8'd1;
              state_d = S_PRE;
            end else if (({1'b0, seg_q} + 9'd1) < {1'b0, segmax_q}) begin
              copy_d  = '0;
              seg_d   = seg_q + 8'd1;
              seq_d   = seq_q + 8'd1;
              state_d = S_PRE;
            end else begin
              seq_d   = seq_q + 8'd1;
              state_d = S_FIN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_FIN: begin
          // Occupies the slot where the next frame would have started
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_redundant_framer.sv
// ---------------------------------------------------------------------------
// tb_tx_redundant_framer
//
// Scoreboard bench for tx_redundant_framer. Each burst request pushes the
// expected {done, tx_en, tx_data} of every byte slot into a queue; a monitor
// pops one entry per advancing edge while the DUT is busy and compares it.
// A receiver-side FCS residue check runs on every complete frame.
// ---------------------------------------------------------------------------
module tb_tx_redundant_framer;

  localparam int ID_OFFSET   = 25;
  localparam int PAYLOAD_LEN = 64;
  localparam int IFG_BYTES   = 12;
  localparam int FRAME_DATA  = ID_OFFSET + 3 + PAYLOAD_LEN;
  localparam int SLOTS       = 8 + FRAME_DATA + 4 + IFG_BYTES;

  // Default header: DST FF..FF, SRC 00:18:3E:02:00:01, ethertype 88B5
  localparam logic [7:0] HDR_BYTES [14] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h00, 8'h18, 8'h3E, 8'h02, 8'h00, 8'h01,
    8'h88, 8'hB5
  };

  logic        clk125MHz = 1'b0;
  logic        resetn;
  logic        tx_adv;
  logic        start;
  logic [7:0]  redundancy;
  logic [7:0]  segment_number_max;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic        done;
`ifdef TX_ERR_INJECT_EN
  logic [7:0]  err_mask;
  logic [7:0]  err_copy;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q [$];
  logic [7:0]  exp_seq = 8'd0;
  int          pace = 1;

  tx_redundant_framer dut (
    .clk125MHz          (clk125MHz),
    .resetn             (resetn),
    .tx_adv             (tx_adv),
    .start              (start),
    .redundancy         (redundancy),
    .segment_number_max (segment_number_max),
`ifdef TX_ERR_INJECT_EN
    .err_mask           (err_mask),
    .err_copy           (err_copy),
`endif
    .pl_addr            (pl_addr),
    .pl_data            (pl_data),
    .tx_data            (tx_data),
    .tx_en              (tx_en),
    .busy               (busy),
    .done               (done)
  );

  // Payload source: byte value equals its index
  assign pl_data = pl_addr[7:0];

  always #4 clk125MHz = ~clk125MHz;

  // Byte strobe: high on every pace-th clock, changed on the falling edge
  initial begin
    int phase;
    phase  = 0;
    tx_adv = 1'b1;
    forever begin
      @(negedge clk125MHz);
      phase++;
      tx_adv = ((phase % pace) == 0);
    end
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Push all 116 slots of one frame: preamble, frame bytes, FCS, IFG
  task automatic pushFrame(input logic [7:0] seq, input logic [7:0] seg,
                           input logic [7:0] copy, input logic [7:0] mask);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({2'b01, 8'h55});
    exp_q.push_back({2'b01, 8'hD5});
    for (int i = 0; i < FRAME_DATA; i++) begin
      if (i < 14)                  b = HDR_BYTES[i];
      else if (i < ID_OFFSET)      b = 8'h00;
      else if (i == ID_OFFSET)     b = seq;
      else if (i == ID_OFFSET + 1) b = seg;
      else if (i == ID_OFFSET + 2) b = copy;
      else begin
        b = 8'(i - ID_OFFSET - 3);
        if (i == ID_OFFSET + 3) b = b ^ mask;
      end
      crc = crc_ref(crc, b);
      exp_q.push_back({2'b01, b});
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) exp_q.push_back({2'b01, fcs[8*k +: 8]});
    for (int k = 0; k < IFG_BYTES; k++) exp_q.push_back(10'd0);
  endtask

  // Queue the expected burst, then pulse start for one clock
  task automatic applyStimulus(input logic [7:0] red, input logic [7:0] segmax,
                               input logic [7:0] mask, input logic [7:0] ecopy);
    int nred, nseg;
    nred = (red == 8'd0) ? 1 : int'(red);
    nseg = (segmax == 8'd0) ? 1 : int'(segmax);
    for (int s = 0; s < nseg; s++) begin
      for (int c = 0; c < nred; c++) begin
        pushFrame(exp_seq, 8'(s), 8'(c), (8'(c) == ecopy) ? mask : 8'h00);
      end
      exp_seq = exp_seq + 8'd1;
    end
    exp_q.push_back({2'b10, 8'h00});
    @(negedge clk125MHz);
    redundancy         = red;
    segment_number_max = segmax;
`ifdef TX_ERR_INJECT_EN
    err_mask = mask;
    err_copy = ecopy;
`endif
    start = 1'b1;
    @(negedge clk125MHz);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk125MHz);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  task automatic doReset();
    @(negedge clk125MHz);
    resetn = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    @(negedge clk125MHz);
    resetn = 1'b1;
  endtask

  // Monitor: one scoreboard pop per advancing edge while busy; holds between
  // strobes; idle outputs quiet; reset state; FCS residue per full frame.
  initial begin
    logic        adv_e, rst_e, busy_prev, prev_en;
    logic [7:0]  prev_data;
    logic [15:0] prev_addr;
    logic [9:0]  e;
    logic [31:0] rx_crc;
    int          fcnt;
    busy_prev = 1'b0;
    prev_en   = 1'b0;
    prev_data = 8'h00;
    prev_addr = 16'h0;
    rx_crc    = 32'hFFFF_FFFF;
    fcnt      = 0;
    forever begin
      @(posedge clk125MHz);
      adv_e = tx_adv;
      rst_e = resetn;
      #1;
      if (!rst_e) begin
        checkOutput("reset_state", 64'({done, busy, tx_en, tx_data, pl_addr}), 64'd0);
        fcnt = 0;
      end else if (busy_prev && adv_e) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_slot", 64'({done, tx_en, tx_data}), 64'h3FF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("slot", 64'({done, tx_en, tx_data}), 64'(e));
          checkOutput("busy", 64'(busy), 64'(!e[9]));
        end
        if (tx_en) begin
          if (fcnt == 0) rx_crc = 32'hFFFF_FFFF;
          if (fcnt >= 8) rx_crc = crc_ref(rx_crc, tx_data);
          fcnt++;
        end else if (fcnt > 0) begin
          if (fcnt == 8 + FRAME_DATA + 4) begin
            checkOutput("fcs_residue", 64'(rx_crc), 64'hDEBB_20E3);
          end
          fcnt = 0;
        end
      end else if (busy_prev) begin
        checkOutput("hold", 64'({done, tx_en, tx_data, pl_addr}),
                    64'({1'b0, prev_en, prev_data, prev_addr}));
      end else if (adv_e) begin
        checkOutput("idle_out", 64'({done, tx_en, tx_data}), 64'd0);
      end
      busy_prev = busy;
      prev_en   = tx_en;
      prev_data = tx_data;
      prev_addr = pl_addr;
    end
  end

  initial begin
    resetn             = 1'b0;
    start              = 1'b0;
    redundancy         = 8'd1;
    segment_number_max = 8'd1;
`ifdef TX_ERR_INJECT_EN
    err_mask = 8'h00;
    err_copy = 8'h00;
`endif
    repeat (3) @(negedge clk125MHz);
    resetn = 1'b1;

    $display("[TB] T1 single frame");
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    waitDone("t1_done", SLOTS + 20);
    repeat (20) @(negedge clk125MHz);

    $display("[TB] T2 redundancy 3 x 2 segments");
    doReset();
    applyStimulus(8'd3, 8'd2, 8'h00, 8'h00);
    waitDone("t2_done", 6 * SLOTS + 20);
    repeat (20) @(negedge clk125MHz);

    $display("[TB] T3 paced 1 in 10");
    pace = 10;
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    waitDone("t3_done", 10 * SLOTS + 40);
    pace = 1;
    repeat (30) @(negedge clk125MHz);

    $display("[TB] T4 zero config, start while busy");
    applyStimulus(8'd0, 8'd0, 8'h00, 8'h00);
    repeat (50) @(negedge clk125MHz);
    redundancy         = 8'd5;
    segment_number_max = 8'd5;
    start              = 1'b1;
    @(negedge clk125MHz);
    start = 1'b0;
    waitDone("t4_done", SLOTS + 20);
    repeat (200) @(negedge clk125MHz);

    $display("[TB] T4 seq wrap");
    doReset();
    applyStimulus(8'd1, 8'd255, 8'h00, 8'h00);
    waitDone("wrap_burst_done", 255 * SLOTS + 50);
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    waitDone("seq255_done", SLOTS + 20);
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    waitDone("seq0_done", SLOTS + 20);
    repeat (10) @(negedge clk125MHz);

    $display("[TB] T5 reset mid payload");
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * SLOTS; i++) begin
        @(posedge clk125MHz);
        #1;
        if (tx_en && pl_addr == 16'd20) begin
          hit = 1'b1;
          break;
        end
      end
      checkOutput("t5_reach_byte20", 64'(hit), 64'd1);
    end
    doReset();
    applyStimulus(8'd1, 8'd1, 8'h00, 8'h00);
    waitDone("t5_done", SLOTS + 20);
    repeat (20) @(negedge clk125MHz);

`ifdef TX_ERR_INJECT_EN
    $display("[TB] T6 error injection on copy 1");
    applyStimulus(8'd3, 8'd1, 8'hFF, 8'd1);
    waitDone("t6_done", 3 * SLOTS + 20);
    repeat (20) @(negedge clk125MHz);
`endif

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
